// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B, one bit per clock LSB first, with a
// registered borrow chain and registered DIFF/BORROW/OVF/BUSY/DONE outputs.
module serial_subtractor #(
    parameter int SIZE = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    output logic [SIZE-1:0] DIFF,
    output logic            BORROW,
    output logic            OVF,
    output logic            BUSY,
    output logic            DONE
);

    localparam int CNT_W = $clog2(SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [SIZE-1:0]   sa_r;
    logic [SIZE-1:0]   sb_r;
    logic [SIZE-1:0]   sd_r;
    logic              br_r;
    logic [CNT_W-1:0]  count_r;
    logic              a_msb_r;
    logic              b_msb_r;

    logic              bit_a_s;
    logic              bit_b_s;
    logic              d_s;
    logic              br_next_s;
    logic              last_s;
    logic [SIZE-1:0]   sd_next_s;

    // One full-subtractor slice on the current LSBs of the operand registers.
    always_comb begin
        bit_a_s   = sa_r[0];
        bit_b_s   = sb_r[0];
        d_s       = bit_a_s ^ bit_b_s ^ br_r;
        br_next_s = (~bit_a_s & bit_b_s) | (~(bit_a_s ^ bit_b_s) & br_r);
        last_s    = (count_r == LAST_CNT);
        sd_next_s = {d_s, sd_r[SIZE-1:1]};
    end

    // Next-state logic; an unused encoding falls back to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (START) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register with BUSY/DONE registered from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            BUSY    <= (state_next_s == ST_SHIFT);
            DONE    <= (state_next_s == ST_HOLD);
        end
    end

    // Operand load, shift datapath and result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sa_r    <= '0;
            sb_r    <= '0;
            sd_r    <= '0;
            br_r    <= 1'b0;
            count_r <= '0;
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            DIFF    <= '0;
            BORROW  <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        sa_r    <= A;
                        sb_r    <= B;
                        sd_r    <= '0;
                        br_r    <= 1'b0;
                        count_r <= '0;
                        a_msb_r <= A[SIZE-1];
                        b_msb_r <= B[SIZE-1];
                    end
                end
                ST_SHIFT: begin
                    sa_r    <= {1'b0, sa_r[SIZE-1:1]};
                    sb_r    <= {1'b0, sb_r[SIZE-1:1]};
                    sd_r    <= sd_next_s;
                    br_r    <= br_next_s;
                    count_r <= count_r + CNT_W'(1);
                    // The final d is the result MSB, so it feeds the overflow test.
                    if (last_s) begin
                        DIFF   <= sd_next_s;
                        BORROW <= br_next_s;
                        OVF    <= (a_msb_r ^ b_msb_r) & (d_s ^ a_msb_r);
                    end
                end
                ST_HOLD: begin
                    sa_r <= sa_r;
                end
                default: begin
                    sa_r    <= '0;
                    sb_r    <= '0;
                    sd_r    <= '0;
                    br_r    <= 1'b0;
                    count_r <= '0;
                    a_msb_r <= 1'b0;
                    b_msb_r <= 1'b0;
                    DIFF    <= '0;
                    BORROW  <= 1'b0;
                    OVF     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model checked
// every cycle, plus directed literal checks and randomized operations.
module tb_serial_subtractor;

    localparam int SIZE = 8;

    logic            CLK;
    logic            RST;
    logic            START;
    logic [SIZE-1:0] A;
    logic [SIZE-1:0] B;
    logic [SIZE-1:0] DIFF;
    logic            BORROW;
    logic            OVF;
    logic            BUSY;
    logic            DONE;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.SIZE(SIZE)) dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
        .DIFF(DIFF), .BORROW(BORROW), .OVF(OVF), .BUSY(BUSY), .DONE(DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void ref_sub(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] d, output logic bo, output logic ov);
        int ru, sa, sb, r;
        ru = int'(a) - int'(b);
        d  = ru[7:0];
        bo = (a < b);
        sa = a[7] ? int'(a) - 256 : int'(a);
        sb = b[7] ? int'(b) - 256 : int'(b);
        r  = sa - sb;
        ov = (r > 127) || (r < -128);
    endfunction

    logic [7:0] m_diff, p_diff;
    logic       m_borrow, m_ovf, m_busy, m_done, p_bo, p_ov;
    int         m_left = 0;
    bit         m_live = 0;

    initial begin
        m_diff = 8'h00; m_borrow = 1'b0; m_ovf = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        p_diff = 8'h00; p_bo = 1'b0; p_ov = 1'b0;
    end

    // Model update at every rising edge, then compare just after it.
    always @(posedge CLK) begin
        if (RST) begin
            m_diff = 8'h00; m_borrow = 1'b0; m_ovf = 1'b0;
            m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_live = 1'b1;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1;
                m_diff = p_diff; m_borrow = p_bo; m_ovf = p_ov;
            end
        end else if (m_done) begin
            if (!START) m_done = 1'b0;
        end else if (START) begin
            ref_sub(A, B, p_diff, p_bo, p_ov);
            m_busy = 1'b1;
            m_left = SIZE;
        end
        #1;
        if (m_live) begin
            check("cyc_diff",   32'(DIFF),   32'(m_diff));
            check("cyc_borrow", 32'(BORROW), 32'(m_borrow));
            check("cyc_ovf",    32'(OVF),    32'(m_ovf));
            check("cyc_busy",   32'(BUSY),   32'(m_busy));
            check("cyc_done",   32'(DONE),   32'(m_done));
        end
    end

    // Raise START at a falling edge; return falling edges until DONE (bounded).
    task automatic start_and_wait(input logic [7:0] a, input logic [7:0] b,
                                  input bit hold, output int lat);
        A = a; B = b; START = 1'b1;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (!hold) START = 1'b0;
        end while (!DONE && lat < 40);
        if (!DONE) check("done_timeout", 32'(DONE), 32'd1);
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                      input logic eb, input logic eo, input string name);
        int lat;
        start_and_wait(a, b, 1'b0, lat);
        check({name, "_lat"},    32'(lat),    32'd9);
        check({name, "_diff"},   32'(DIFF),   32'(ed));
        check({name, "_borrow"}, 32'(BORROW), 32'(eb));
        check({name, "_ovf"},    32'(OVF),    32'(eo));
        START = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        int lat;
        logic [7:0] ra, rb, ed;
        logic eb, eo;
        RST = 1'b1; START = 1'b0; A = 8'h00; B = 8'h00;
        repeat (2) @(negedge CLK);
        check("rst_diff", 32'(DIFF), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        check("rst_done", 32'(DONE), 32'h0);
        RST = 1'b0;
        @(negedge CLK);

        op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, "t5a_23");
        op(8'h23, 8'h5A, 8'hC9, 1'b1, 1'b0, "t23_5a");
        op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "t80_01");
        op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "t7f_ff");
        op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "tff_ff");
        op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "t00_01");

        // Held START through HOLD with changing operands: no restart.
        start_and_wait(8'h11, 8'h22, 1'b1, lat);
        check("hold_first", 32'(DIFF), 32'hEF);
        for (int i = 0; i < 5; i++) begin
            A = 8'($urandom); B = 8'($urandom);
            @(negedge CLK);
            check("hold_done", 32'(DONE), 32'd1);
            check("hold_diff", 32'(DIFF), 32'hEF);
        end
        START = 1'b0;
        @(negedge CLK);
        op(8'h40, 8'h10, 8'h30, 1'b0, 1'b0, "restart");

        // Operands and START wiggled during SHIFT are ignored.
        A = 8'h9C; B = 8'h3E; START = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
            @(negedge CLK);
            check("shift_prev_diff", 32'(DIFF), 32'h30);
            A = 8'($urandom); B = 8'($urandom); START = 1'($urandom);
        end
        @(negedge CLK);
        check("perturb_done",   32'(DONE),   32'd1);
        check("perturb_diff",   32'(DIFF),   32'h5E);
        check("perturb_borrow", 32'(BORROW), 32'd0);
        check("perturb_ovf",    32'(OVF),    32'd1);
        START = 1'b0;
        @(negedge CLK);

        // Reset in the middle of a shift sequence.
        A = 8'h12; B = 8'h34; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_diff", 32'(DIFF), 32'h0);
        check("midrst_ovf",  32'(OVF),  32'h0);
        check("midrst_busy", 32'(BUSY), 32'h0);
        check("midrst_done", 32'(DONE), 32'h0);
        RST = 1'b0;
        op(8'h12, 8'h34, 8'hDE, 1'b1, 1'b0, "after_rst");

        // Randomized operations, occasionally aborted by reset.
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                A = ra; B = rb; START = 1'b1;
                @(negedge CLK);
                START = 1'b0;
                repeat ($urandom_range(0, 7)) @(negedge CLK);
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
            end else begin
                ref_sub(ra, rb, ed, eb, eo);
                op(ra, rb, ed, eb, eo, "rand");
                repeat ($urandom_range(0, 2)) @(negedge CLK);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
